rv32_hart_scheduler: RTL and testbench
======================================

RV32_HART_SCHEDULER -- requirements
Module: rv32_hart_scheduler

Interface
REQ-001 Parameter NUM_HARTS, default 8, number of hardware threads sharing the fetch/decode/execute datapath; legal values 2..16.
REQ-002 Parameter PIPE_DEPTH, default 5, pipeline stages that must drain after issue stops; legal values 1..15.
REQ-003 Derived HART_W = clog2(NUM_HARTS).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 hart_enable  input  NUM_HARTS  per-hart run enable from configuration CSR.
REQ-007 stall  input  1  pipeline back-pressure; freezes issue.
REQ-008 trap_valid  input  1  decoder flagged an illegal/unknown instruction.
REQ-009 trap_hart_id  input  HART_W  hart owning the trapping instruction.
REQ-010 trap_clear  input  NUM_HARTS  per-hart trap acknowledge from debug/host.
REQ-011 halt_req  input  1  level request to stop issuing and drain the pipeline.
REQ-012 resume_req  input  1  pulse returning from HALTED to RUN.
REQ-013 sched_valid  output  1  sched_hart_id is a valid issue slot this cycle.
REQ-014 sched_hart_id  output  HART_W  hart selected to fetch this cycle.
REQ-015 hart_trapped  output  NUM_HARTS  sticky per-hart trap status.
REQ-016 sched_state  output  2  00 RUN, 01 DRAIN, 10 HALTED.
REQ-017 drained  output  1  high only in HALTED.

Function
REQ-018 All outputs registered; no combinational input-to-output path.
REQ-019 Eligible mask = hart_enable & ~hart_trapped_next, where hart_trapped_next includes a trap arriving this cycle.
REQ-020 In RUN with stall=0: selection is round-robin, searching from (last issued id + 1) modulo NUM_HARTS upward with wrap, first eligible hart wins; latched into sched_hart_id next edge with sched_valid=1.
REQ-021 In RUN with stall=0 and no eligible hart: sched_valid=0 next cycle; sched_hart_id and round-robin pointer hold.
REQ-022 stall=1: sched_valid, sched_hart_id, and pointer hold their values; hart_trapped still updates.
REQ-023 Round-robin pointer updates only on a valid issue; a single eligible hart is issued every non-stalled cycle.
REQ-024 trap_valid sets hart_trapped[trap_hart_id] on the next edge; trap_hart_id >= NUM_HARTS is ignored.
REQ-025 trap_clear[i] clears hart_trapped[i] on the next edge; simultaneous trap and clear for the same hart leaves bit set (trap wins).
REQ-026 RUN -> DRAIN when halt_req=1 (checked before issue; no issue that cycle; sched_valid=0 next cycle); drain counter loads PIPE_DEPTH-1.
REQ-027 DRAIN: sched_valid=0; counter decrements each cycle regardless of stall; at 0 transition to HALTED.
REQ-028 HALTED: sched_valid=0, drained=1; resume_req=1 -> RUN next edge; resume_req ignored in RUN/DRAIN; halt_req ignored in DRAIN/HALTED.
REQ-029 HALTED with resume_req=1 and halt_req=1 simultaneously: go to RUN, then re-enter DRAIN on following cycle since halt_req is still high.
REQ-030 Unused sched_state encoding 11 recovers to HALTED next edge.

Reset
REQ-031 rst_n=0 at a rising edge: sched_state=RUN, sched_valid=0, sched_hart_id=0, pointer = NUM_HARTS-1 (first issue is hart 0), hart_trapped=0, drain counter=0, drained=0.
REQ-032 Reset overrides every input, including mid-DRAIN and same-cycle trap_valid.

Verification
REQ-033 NUM_HARTS=8, all enabled, no stall, 10 cycles after reset release -> sched_hart_id 0,1,2..7,0,1 with sched_valid=1 every cycle.
REQ-034 hart_enable=8'b0010_0100 -> sequence 2,5,2,5; set hart_enable=0 -> sched_valid=0 next cycle, id holds at last value.
REQ-035 trap_valid with trap_hart_id=3 in the cycle hart 3 would be chosen -> hart 4 issued, hart_trapped=8'h08; trap_clear=8'h08 -> hart 3 reappears on the next wrap.
REQ-036 stall high 3 cycles mid-sequence at id=6 -> id stays 6, sched_valid stays 1; release -> 7.
REQ-037 PIPE_DEPTH=5, halt_req asserted in RUN -> sched_valid=0 next cycle, DRAIN for 5 cycles, then HALTED, drained=1; resume_req -> RUN, issue resumes at pointer+1.
REQ-038 rst_n=0 during DRAIN with hart_trapped=8'hFF -> next cycle RUN, hart_trapped=0, then id 0 issued.

Source files
------------

// File: rtl/rv32_hart_scheduler.sv
// Round-robin fetch scheduler for a barrel-threaded RV32 core: picks one eligible
// hart per cycle, tracks sticky per-hart traps, and drains the pipeline on halt.
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | issuing one eligible hart per non-stalled cycle
// DRAIN  | issue stopped, counting down PIPE_DEPTH cycles for in-flight ops
// HALTED | pipeline empty, o_drained=1, waiting for i_resume_req
module rv32_hart_scheduler #(
  parameter int NUM_HARTS  = 8,
  parameter int PIPE_DEPTH = 5,
  localparam int HART_W    = $clog2(NUM_HARTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_HARTS-1:0] i_hart_enable,
  input  logic                 i_stall,
  input  logic                 i_trap_valid,
  input  logic [HART_W-1:0]    i_trap_hart_id,
  input  logic [NUM_HARTS-1:0] i_trap_clear,
  input  logic                 i_halt_req,
  input  logic                 i_resume_req,
  output logic                 o_sched_valid,
  output logic [HART_W-1:0]    o_sched_hart_id,
  output logic [NUM_HARTS-1:0] o_hart_trapped,
  output logic [1:0]           o_sched_state,
  output logic                 o_drained
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_DRAIN  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;
  localparam int         CNT_W     = 4;

  logic [1:0]           r_state;
  logic                 r_valid;
  logic [HART_W-1:0]    r_hart_id;
  logic [HART_W-1:0]    r_ptr;
  logic [NUM_HARTS-1:0] r_trapped;
  logic [CNT_W-1:0]     r_drain_cnt;
  logic                 r_drained;

  logic [1:0]           w_state_nxt;
  logic                 w_valid_nxt;
  logic [HART_W-1:0]    w_hart_id_nxt;
  logic [HART_W-1:0]    w_ptr_nxt;
  logic [CNT_W-1:0]     w_drain_cnt_nxt;
  logic                 w_drained_nxt;
  logic [NUM_HARTS-1:0] w_trapped_nxt;
  logic [NUM_HARTS-1:0] w_elig;
  logic                 w_found;
  logic [HART_W-1:0]    w_pick;
  int                   w_idx;

  // Trap set wins over a same-cycle clear; ids beyond NUM_HARTS match no bit.
  always_comb begin
    w_trapped_nxt = r_trapped & ~i_trap_clear;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (i_trap_valid && (i_trap_hart_id == HART_W'(i))) begin
        w_trapped_nxt[i] = 1'b1;
      end
    end
  end

  assign w_elig = i_hart_enable & ~w_trapped_nxt;

  // Search starts just past the last issued hart, wrapping once around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = 0;
    for (int k = 1; k <= NUM_HARTS; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_HARTS) begin
        w_idx = w_idx - NUM_HARTS;
      end
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = HART_W'(w_idx);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_valid     <= 1'b0;
      r_hart_id   <= '0;
      r_ptr       <= HART_W'(NUM_HARTS - 1);
      r_trapped   <= '0;
      r_drain_cnt <= '0;
      r_drained   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= w_valid_nxt;
      r_hart_id   <= w_hart_id_nxt;
      r_ptr       <= w_ptr_nxt;
      r_trapped   <= w_trapped_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_drained   <= w_drained_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (i_halt_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (r_drain_cnt == '0) w_state_nxt = ST_HALTED;
      ST_HALTED: if (i_resume_req) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_HALTED;
    endcase
  end

  // Halt is checked before issue, so a halting RUN cycle never issues.
  always_comb begin
    w_valid_nxt     = r_valid;
    w_hart_id_nxt   = r_hart_id;
    w_ptr_nxt       = r_ptr;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (i_halt_req) begin
          w_valid_nxt     = 1'b0;
          w_drain_cnt_nxt = CNT_W'(PIPE_DEPTH - 1);
        end else if (!i_stall) begin
          w_valid_nxt = w_found;
          if (w_found) begin
            w_hart_id_nxt = w_pick;
            w_ptr_nxt     = w_pick;
          end
        end
      end
      ST_DRAIN: begin
        w_valid_nxt = 1'b0;
        if (r_drain_cnt != '0) begin
          w_drain_cnt_nxt = r_drain_cnt - 1'b1;
        end
      end
      default: w_valid_nxt = 1'b0;
    endcase
    w_drained_nxt = (w_state_nxt == ST_HALTED);
  end

  assign o_sched_valid   = r_valid;
  assign o_sched_hart_id = r_hart_id;
  assign o_hart_trapped  = r_trapped;
  assign o_sched_state   = r_state;
  assign o_drained       = r_drained;

endmodule

// File: tb/tb_rv32_hart_scheduler.sv
// Self-checking bench for rv32_hart_scheduler: directed scenarios plus a random
// phase, all checked against a cycle-level behavioural model of the scheduler.
module tb_rv32_hart_scheduler;

  localparam int NH     = 8;
  localparam int PD     = 5;
  localparam int HW     = $clog2(NH);

  logic          clk;
  logic          rst_n;
  logic [NH-1:0] hart_enable;
  logic          stall;
  logic          trap_valid;
  logic [HW-1:0] trap_hart_id;
  logic [NH-1:0] trap_clear;
  logic          halt_req;
  logic          resume_req;
  logic          sched_valid;
  logic [HW-1:0] sched_hart_id;
  logic [NH-1:0] hart_trapped;
  logic [1:0]    sched_state;
  logic          drained;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode 0=run 1=drain 2=halted
  int            m_mode;
  int            m_valid;
  int            m_id;
  int            m_last;
  int            m_drain_left;
  logic [NH-1:0] m_trapped;

  rv32_hart_scheduler #(.NUM_HARTS(NH), .PIPE_DEPTH(PD)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_hart_enable   (hart_enable),
    .i_stall         (stall),
    .i_trap_valid    (trap_valid),
    .i_trap_hart_id  (trap_hart_id),
    .i_trap_clear    (trap_clear),
    .i_halt_req      (halt_req),
    .i_resume_req    (resume_req),
    .o_sched_valid   (sched_valid),
    .o_sched_hart_id (sched_hart_id),
    .o_hart_trapped  (hart_trapped),
    .o_sched_state   (sched_state),
    .o_drained       (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [NH-1:0] tr;
    logic [NH-1:0] elig;
    int            cand;
    int            pick;
    bit            found;
    if (!rst_n) begin
      m_mode = 0; m_valid = 0; m_id = 0; m_last = NH - 1;
      m_trapped = '0; m_drain_left = 0;
      return;
    end
    tr = m_trapped & ~trap_clear;
    if (trap_valid && int'(trap_hart_id) < NH) tr[trap_hart_id] = 1'b1;
    elig = hart_enable & ~tr;
    case (m_mode)
      0: begin
        if (halt_req) begin
          m_mode = 1; m_valid = 0; m_drain_left = PD;
        end else if (!stall) begin
          found = 0; pick = 0;
          for (int k = 1; k <= NH; k++) begin
            cand = (m_last + k) % NH;
            if (!found && elig[cand]) begin found = 1; pick = cand; end
          end
          if (found) begin
            m_valid = 1; m_id = pick; m_last = pick;
          end else begin
            m_valid = 0;
          end
        end
      end
      1: begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 2;
      end
      default: if (resume_req) m_mode = 0;
    endcase
    m_trapped = tr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("valid",   32'(sched_valid),   32'(m_valid));
    if (m_valid != 0 || m_mode != 0) check_eq("hart_id", 32'(sched_hart_id), 32'(m_id));
    else check_eq("hart_id_hold", 32'(sched_hart_id), 32'(m_id));
    check_eq("trapped", 32'(hart_trapped),  32'(m_trapped));
    check_eq("state",   32'(sched_state),   32'(m_mode));
    check_eq("drained", 32'(drained),       32'(m_mode == 2));
  endtask

  task automatic idle_inputs();
    stall = 0; trap_valid = 0; trap_hart_id = '0; trap_clear = '0;
    halt_req = 0; resume_req = 0;
  endtask

  initial begin
    int seq33 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int seq34 [4]  = '{2, 5, 2, 5};
    m_mode = 0; m_valid = 0; m_id = 0; m_last = NH - 1; m_trapped = '0; m_drain_left = 0;
    rst_n = 0; hart_enable = '1; idle_inputs();
    #1;
    tick(); tick();
    check_eq("rst_state",   32'(sched_state),  32'd0);
    check_eq("rst_valid",   32'(sched_valid),  32'd0);
    check_eq("rst_id",      32'(sched_hart_id), 32'd0);
    check_eq("rst_trapped", 32'(hart_trapped), 32'd0);
    check_eq("rst_drained", 32'(drained),      32'd0);

    // all enabled: plain round robin from hart 0
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("rr_all_id", 32'(sched_hart_id), 32'(seq33[i]));
      check_eq("rr_all_valid", 32'(sched_valid), 32'd1);
    end

    hart_enable = 8'b0010_0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rr_sparse_id", 32'(sched_hart_id), 32'(seq34[i]));
    end
    hart_enable = '0;
    tick();
    check_eq("none_valid", 32'(sched_valid), 32'd0);
    check_eq("none_hold",  32'(sched_hart_id), 32'd5);
    tick();

    // trap on the hart about to be chosen
    hart_enable = '1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("pre_trap_id", 32'(sched_hart_id), 32'd2);
    trap_valid = 1; trap_hart_id = 3;
    tick();
    check_eq("trap_skip_id", 32'(sched_hart_id), 32'd4);
    check_eq("trap_bit",     32'(hart_trapped), 32'h08);
    trap_valid = 0; trap_clear = 8'h08;
    tick();
    check_eq("trap_cleared", 32'(hart_trapped), 32'h00);
    trap_clear = '0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("trap_reappear", 32'(sched_hart_id), 32'd3);

    // stall holds id and valid
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_stall_id", 32'(sched_hart_id), 32'd6);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_id",    32'(sched_hart_id), 32'd6);
      check_eq("stall_valid", 32'(sched_valid),   32'd1);
    end
    stall = 0;
    tick();
    check_eq("post_stall_id", 32'(sched_hart_id), 32'd7);

    // halt / drain / resume
    halt_req = 1;
    tick();
    check_eq("halt_valid", 32'(sched_valid), 32'd0);
    check_eq("halt_state", 32'(sched_state), 32'd1);
    halt_req = 0;
    for (int i = 0; i < PD - 1; i++) begin
      tick();
      check_eq("drain_state", 32'(sched_state), 32'd1);
    end
    tick();
    check_eq("halted_state",   32'(sched_state), 32'd2);
    check_eq("halted_drained", 32'(drained),     32'd1);
    tick();
    resume_req = 1;
    tick();
    check_eq("resume_state", 32'(sched_state), 32'd0);
    resume_req = 0;
    tick();
    check_eq("resume_id",    32'(sched_hart_id), 32'd0);
    check_eq("resume_valid", 32'(sched_valid),   32'd1);

    // reset mid-drain with every hart trapped
    trap_valid = 1;
    for (int i = 0; i < NH; i++) begin
      trap_hart_id = HW'(i);
      tick();
    end
    trap_valid = 0;
    check_eq("all_trapped", 32'(hart_trapped), 32'hFF);
    halt_req = 1;
    tick(); tick();
    halt_req = 0;
    rst_n = 0; trap_valid = 1; trap_hart_id = 2;
    tick();
    check_eq("rst_drain_state",   32'(sched_state),  32'd0);
    check_eq("rst_drain_trapped", 32'(hart_trapped), 32'd0);
    rst_n = 1; trap_valid = 0;
    tick();
    check_eq("rst_drain_first_id", 32'(sched_hart_id), 32'd0);

    // halt and resume together from HALTED
    halt_req = 1;
    for (int i = 0; i < PD + 1; i++) tick();
    check_eq("hr_halted", 32'(sched_state), 32'd2);
    resume_req = 1;
    tick();
    check_eq("hr_run", 32'(sched_state), 32'd0);
    resume_req = 0;
    tick();
    check_eq("hr_redrain", 32'(sched_state), 32'd1);
    halt_req = 0;

    // random phase
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      hart_enable  = ($urandom_range(0, 3) == 0) ? NH'($urandom) : (NH'($urandom) | NH'($urandom));
      stall        = ($urandom_range(0, 4) == 0);
      trap_valid   = ($urandom_range(0, 9) == 0);
      trap_hart_id = HW'($urandom);
      trap_clear   = ($urandom_range(0, 5) == 0) ? NH'($urandom) : '0;
      if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
      resume_req   = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
